// File: rtl/pc_fetch_unit_if.sv
// Fetch-side bundle of the PC unit: redirect sources, control and the fetch handshake.
// The master modport is the PC unit itself; the slave modport is the core/fetch side.
interface pc_fetch_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
);
    logic [1:0]       pc_src;
    logic [XLEN-1:0]  pc_target;
    logic [XLEN-1:0]  alu_result;
    logic             trap;
    logic [XLEN-1:0]  trap_vector;
    logic             instr_is16;
    logic             stall;
    logic             halt;
    logic             resume;
    logic             fetch_rdy;

    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_plus_len;
    logic             fetch_vld;
    logic             misalign_fault;
    logic [XLEN-1:0]  misalign_addr;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        input  pc_src, pc_target, alu_result, trap, trap_vector, instr_is16,
               stall, halt, resume, fetch_rdy,
        output pc, pc_plus_len, fetch_vld, misalign_fault, misalign_addr, fetch_count
    );

    modport slave (
        output pc_src, pc_target, alu_result, trap, trap_vector, instr_is16,
               stall, halt, resume, fetch_rdy,
        input  pc, pc_plus_len, fetch_vld, misalign_fault, misalign_addr, fetch_count
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter with prioritised next-PC select (trap > stall > redirect > sequential), halt/resume FSM, fetch counter.
// One-edge latency for all state; fetch_rdy low only holds sequential flow, redirects and traps still load.
module pc_fetch_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter bit              COMPRESSED   = 1'b0,
    parameter int unsigned     CNT_W        = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    pc_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  misalign_addr_q, misalign_addr_d;
    logic             fetch_vld_q, fetch_vld_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [XLEN-1:0]  step_len;
    logic [XLEN-1:0]  pc_plus_len;
    logic [XLEN-1:0]  trap_pc;
    logic [XLEN-1:0]  jalr_pc;
    logic [XLEN-1:0]  redirect_pc;
    logic             redirect;
    logic             misaligned;
    logic             accept;

    assign step_len    = (COMPRESSED && bus.instr_is16) ? XLEN'(2) : XLEN'(4);
    assign pc_plus_len = pc_q + step_len;
    assign trap_pc     = bus.trap_vector & ~XLEN'(3);
    assign jalr_pc     = bus.alu_result & ~XLEN'(1);
    assign redirect    = (bus.pc_src == 2'b01) || (bus.pc_src == 2'b10);
    assign redirect_pc = (bus.pc_src == 2'b01) ? bus.pc_target : jalr_pc;
    // Without compressed support only bit 1 can misalign; bit 0 is never set on a target.
    assign misaligned  = !COMPRESSED && redirect_pc[1];
    assign accept      = (state_q == ST_RUN) && fetch_vld_q && bus.fetch_rdy && !bus.stall;

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        fault_d         = 1'b0;
        misalign_addr_d = misalign_addr_q;
        count_d         = accept ? count_q + CNT_W'(1) : count_q;

        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.trap) begin
                    pc_d = trap_pc;
                end else begin
                    if (!bus.stall) begin
                        if (redirect) begin
                            if (misaligned) begin
                                pc_d            = trap_pc;
                                fault_d         = 1'b1;
                                misalign_addr_d = redirect_pc;
                            end else begin
                                pc_d = redirect_pc;
                            end
                        end else if (bus.pc_src == 2'b00 && bus.fetch_rdy) begin
                            pc_d = pc_plus_len;
                        end
                    end
                    // The PC update of the halting edge still takes effect.
                    if (bus.halt) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                if (bus.trap) begin
                    pc_d    = trap_pc;
                    state_d = ST_RUN;
                end else if (bus.resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        fetch_vld_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= ST_BOOT;
            pc_q            <= RESET_VECTOR;
            fetch_vld_q     <= 1'b0;
            fault_q         <= 1'b0;
            misalign_addr_q <= '0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            fetch_vld_q     <= fetch_vld_d;
            fault_q         <= fault_d;
            misalign_addr_q <= misalign_addr_d;
            count_q         <= count_d;
        end
    end

    assign bus.pc             = pc_q;
    assign bus.pc_plus_len    = pc_plus_len;
    assign bus.fetch_vld      = fetch_vld_q;
    assign bus.misalign_fault = fault_q;
    assign bus.misalign_addr  = misalign_addr_q;
    assign bus.fetch_count    = count_q;
endmodule
